// File: rtl/serdes_pkg.sv
// Shared definitions for the bit-serial link: receiver FSM encoding and frame-format levels.
package serdes_pkg;

  localparam int DEFAULT_DATA_W = 8;

  localparam logic START_BIT  = 1'b0;
  localparam logic IDLE_LEVEL = 1'b1;
  localparam logic STOP_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DATA      = 3'd1,
    ST_PARITY    = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_e;

endpackage

// File: rtl/serial_frame_rx_if.sv
// Parallel valid/ready word output of the serial frame receiver.
interface serial_frame_rx_if #(
  parameter int DATA_W = serdes_pkg::DEFAULT_DATA_W
);

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/rx_hold_reg.sv
// One-entry valid/ready holding register; flags an overrun when a word arrives while full.
module rx_hold_reg
  import serdes_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  input  logic              ready,
  output logic              overrun
);

  logic accept;
  logic free;

  // A word being accepted this edge frees the slot for a simultaneous load.
  assign accept = valid & ready;
  assign free   = ~valid | accept;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= load & ~free;
      if (load && free) begin
        data  <= load_data;
        valid <= 1'b1;
      end else if (accept) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Bit-serial frame receiver: start-bit hunt, LSB-first shift, even parity and stop checks,
// and a one-entry parallel valid/ready output.
module serial_frame_rx
  import serdes_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int PARITY_EN = 1,
  parameter int STOP_BITS = 1
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                ser_in,
  serial_frame_rx_if.master   out_bus,
  output logic                parity_err,
  output logic                frame_err,
  output logic                overrun,
  output logic                busy
);

  localparam int                CNT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic [1:0]        LAST_STOP = 2'(STOP_BITS - 1);

  rx_state_e         state;
  rx_state_e         state_next;
  logic [CNT_W-1:0]  bit_cnt;
  logic [1:0]        stop_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic              par_bit;
  logic              frame_end;
  logic              stop_bad;

  logic              done_p0;
  logic              stop_bad_p0;
  logic              par_bad_p0;
  logic              load_p1;
  logic [DATA_W-1:0] hold_data;
  logic              hold_valid;

  function automatic logic parity_bad(input logic [DATA_W-1:0] word, input logic pbit);
    return (PARITY_EN != 0) && ((^word) != pbit);
  endfunction

  always_comb begin
    state_next = state;
    frame_end  = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      ST_IDLE:      if (ser_in == START_BIT) state_next = ST_DATA;
      ST_DATA:      if (bit_cnt == LAST_BIT)
                      state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY:    state_next = ST_STOP;
      ST_STOP: begin
        if (ser_in != STOP_LEVEL) begin
          stop_bad   = 1'b1;
          frame_end  = 1'b1;
          state_next = ST_WAIT_IDLE;
        end else if (stop_cnt == LAST_STOP) begin
          frame_end  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      // A held-low break must not be mistaken for a train of start bits.
      ST_WAIT_IDLE: if (ser_in == IDLE_LEVEL) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      stop_cnt <= '0;
    end else begin
      state    <= state_next;
      bit_cnt  <= (state == ST_DATA) ? bit_cnt + 1'b1 : '0;
      stop_cnt <= (state == ST_STOP) ? stop_cnt + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_DATA)   shift_reg[bit_cnt] <= ser_in;
    if (state == ST_PARITY) par_bit            <= ser_in;
  end

  // Stage p0: frame verdict captured on the edge that samples the final stop bit.
  always_ff @(posedge clk) begin
    if (!nreset) done_p0 <= 1'b0;
    else         done_p0 <= frame_end;
  end

  always_ff @(posedge clk) begin
    stop_bad_p0 <= stop_bad;
    par_bad_p0  <= parity_bad(shift_reg, par_bit);
  end

  // Stage p1: error pulses and hand-off to the holding register. shift_reg is still
  // intact here because the next frame's first data bit lands one edge later.
  assign load_p1 = done_p0 & ~stop_bad_p0 & ~par_bad_p0;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      frame_err  <= done_p0 & stop_bad_p0;
      parity_err <= done_p0 & ~stop_bad_p0 & par_bad_p0;
    end
  end

  rx_hold_reg #(.DATA_W(DATA_W)) u_hold (
    .clk       (clk),
    .nreset    (nreset),
    .load      (load_p1),
    .load_data (shift_reg),
    .data      (hold_data),
    .valid     (hold_valid),
    .ready     (out_bus.out_ready),
    .overrun   (overrun)
  );

  assign out_bus.out_data  = hold_data;
  assign out_bus.out_valid = hold_valid;
  assign busy              = (state != ST_IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx: directed frames plus randomized traffic.
module tb_serial_frame_rx;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic ser_in = 1'b1;
  logic parity_err, frame_err, overrun, busy;

  serial_frame_rx_if #(.DATA_W(8)) bus ();

  serial_frame_rx #(.DATA_W(8), .PARITY_EN(1), .STOP_BITS(1)) dut (
    .clk        (clk),
    .nreset     (nreset),
    .ser_in     (ser_in),
    .out_bus    (bus),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected responses: accepted words in order, and error pulses (1=parity, 2=frame, 3=overrun).
  logic [7:0] exp_words[$];
  int         exp_err[$];
  int         beat_q[$];
  int last_t0 = 0, last_valid_rise = -1, last_perr = -1, last_ovr = -1, accept_cnt = 0;
  bit prev_valid, prev_pe, prev_fe, prev_ov;
  bit rdy_mode = 1'b0;
  logic ready_manual = 1'b0;
  int valid_age = 0;
  int mon_np, mon_kind;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Consumer: manual level, or random with a guarantee that no word waits more than a few cycles.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      valid_age = bus.out_valid ? valid_age + 1 : 0;
      bus.out_ready = rdy_mode ? ((valid_age >= 4) || ($urandom_range(0, 3) != 0)) : ready_manual;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a word transfer or an error pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (!nreset) begin
        prev_valid = 0; prev_pe = 0; prev_fe = 0; prev_ov = 0;
      end else begin
        if (bus.out_valid && !prev_valid) last_valid_rise = cyc;
        if (bus.out_valid && bus.out_ready) begin
          accept_cnt++;
          beat_q.push_back(cyc);
          if (exp_words.size() == 0) begin
            n_vec++; n_miss++;
            $display("FAIL unexpected_word: got 0x%0h, no word expected", bus.out_data);
          end else begin
            check("word_data", bus.out_data, exp_words.pop_front());
          end
        end
        mon_np = int'(parity_err) + int'(frame_err) + int'(overrun);
        if (mon_np > 0) begin
          if (mon_np > 1) check("pulse_onehot", mon_np, 1);
          mon_kind = parity_err ? 1 : (frame_err ? 2 : 3);
          if (parity_err) last_perr = cyc;
          if (overrun) last_ovr = cyc;
          check("pulse_width", {prev_pe & parity_err, prev_fe & frame_err, prev_ov & overrun}, 0);
          if (exp_err.size() == 0) begin
            n_vec++; n_miss++;
            $display("FAIL unexpected_pulse: got kind %0d, no pulse expected", mon_kind);
          end else begin
            check("err_kind", mon_kind, exp_err.pop_front());
          end
        end
        prev_valid = bus.out_valid; prev_pe = parity_err; prev_fe = frame_err; prev_ov = overrun;
      end
    end
  end

  task automatic send_bit(input logic b);
    ser_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) send_bit(1'b1);
  endtask

  // Reference model: a frame whose stop bit is low is a frame error; otherwise the XOR over
  // data and parity must be zero; a good word is dropped only if the caller says the slot is full.
  task automatic send_frame(input logic [7:0] d, input bit flip_par, input bit bad_stop,
                            input int low_after, input bit exp_ovr);
    logic p;
    p = (^d) ^ flip_par;
    if (bad_stop)                 exp_err.push_back(2);
    else if (((^d) ^ p) != 1'b0)  exp_err.push_back(1);
    else if (exp_ovr)             exp_err.push_back(3);
    else                          exp_words.push_back(d);
    send_bit(1'b0);
    last_t0 = cyc;
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(!bad_stop);
    if (bad_stop) begin
      repeat (low_after) send_bit(1'b0);
      send_bit(1'b1);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_perr", parity_err, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    nreset = 1'b1;
    idle(2);

    ready_manual = 1'b0;
    send_frame(8'hA5, 0, 0, 0, 0);
    for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge clk);
    check("a5_valid", bus.out_valid, 1);
    check("a5_latency", last_valid_rise - last_t0, 11);
    check("a5_data", bus.out_data, 8'hA5);
    @(posedge clk);
    #1;
    ready_manual = 1'b1;
    idle(3);
    ready_manual = 1'b0;

    send_frame(8'h3C, 1, 0, 0, 0);
    idle(4);
    check("3c_perr_latency", last_perr - last_t0, 11);
    check("3c_valid", bus.out_valid, 0);

    ready_manual = 1'b1;
    send_frame(8'h81, 0, 1, 20, 0);
    send_bit(1'b1);
    send_frame(8'h55, 0, 0, 0, 0);
    idle(4);

    ready_manual = 1'b0;
    send_frame(8'h11, 0, 0, 0, 0);
    send_frame(8'h22, 0, 0, 0, 1);
    idle(4);
    check("ovr_latency", last_ovr - last_t0, 11);
    check("ovr_hold_data", bus.out_data, 8'h11);
    check("ovr_hold_valid", bus.out_valid, 1);
    a0 = accept_cnt;
    ready_manual = 1'b1;
    idle(5);
    check("ovr_accepts", accept_cnt - a0, 1);

    beat_q.delete();
    send_frame(8'h00, 0, 0, 0, 0);
    send_frame(8'hFF, 0, 0, 0, 0);
    send_frame(8'h5A, 0, 0, 0, 0);
    idle(4);
    check("gap_beats", beat_q.size(), 3);
    for (int i = 1; i < beat_q.size(); i++) check("gap_spacing", beat_q[i] - beat_q[i-1], 11);

    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    @(negedge clk);
    check("midrst_busy_before", busy, 1);
    nreset = 1'b0;
    ser_in = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_busy_after", busy, 0);
    check("midrst_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;
    nreset = 1'b1;
    send_bit(1'b1);
    send_frame(8'h0F, 0, 0, 0, 0);
    idle(4);

    rdy_mode = 1'b1;
    repeat (40) begin
      logic [7:0] d;
      bit fp, bs;
      d  = 8'($urandom);
      fp = ($urandom_range(0, 7) == 0);
      bs = !fp && ($urandom_range(0, 7) == 0);
      send_frame(d, fp, bs, int'($urandom_range(0, 3)), 0);
      idle(int'($urandom_range(0, 2)));
    end
    rdy_mode = 1'b0;
    ready_manual = 1'b1;
    idle(30);

    check("words_left", exp_words.size(), 0);
    check("errs_left", exp_err.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Deserializing receiver for the single-lane bit-serial link driven by the team's serializer.
- Hunts for a start bit, shifts in one data word LSB-first, checks parity and stop bit, and presents the word on a parallel valid/ready output.
- Sits at the far end of the serial lane, feeding parallel consumers such as the loopback checker or a downstream FIFO.
- Runs at one bit per clock in the serializer's clock domain; no oversampling, no CDC.

Parameters:
- DATA_W, 8: data bits per frame.
- PARITY_EN, 1: 1 = even parity bit follows the data bits; 0 = no parity bit.
- STOP_BITS, 1: number of stop bits (1 or 2); all must be 1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- nreset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- ser_in  input  1  serial line; idle high.
- out_data  output  DATA_W  received word, stable while out_valid=1.
- out_valid  output  1  word available.
- out_ready  input  1  consumer accepts the word; transfer on clk edge with out_valid & out_ready.
- parity_err  output  1  one-cycle pulse: frame dropped, parity mismatch.
- frame_err  output  1  one-cycle pulse: frame dropped, a stop bit was 0.
- overrun  output  1  one-cycle pulse: good frame dropped because the holding register was full.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (nreset=0 at an edge):
  - state=IDLE; out_data=0; out_valid=0; parity_err=0; frame_err=0; overrun=0; busy=0.
  - Reset mid-frame abandons the frame silently; no error pulse.
- Frame on the line: start(0), DATA_W data bits LSB first, parity (if PARITY_EN; even, so XOR of data and parity = 0), STOP_BITS ones.
- FSM states: IDLE, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE: ser_in=0 -> DATA, bit counter=0.
  - DATA: shift ser_in into bit[cnt]; at cnt=DATA_W-1 -> PARITY if PARITY_EN, else STOP.
  - PARITY: capture parity bit -> STOP with stop counter=0.
  - STOP:
    - ser_in=0 -> frame_err pulse, word dropped, -> WAIT_IDLE.
    - Last stop bit =1 -> frame complete, -> IDLE.
  - WAIT_IDLE: stay until ser_in=1, then -> IDLE. Prevents a held-low (break) line being taken as repeated start bits.
- Back-to-back frames: in IDLE the cycle after the last stop bit, a 0 is a new start bit; zero-gap frames are supported.
- Completion, evaluated at the edge that samples the last stop bit:
  - Frame error has priority and drops the word.
  - Else, parity mismatch -> parity_err pulse, word dropped.
  - Else, holding register free or being emptied this cycle (out_valid=0, or out_valid & out_ready) -> load out_data, out_valid=1 on the next cycle.
  - Else -> overrun pulse; old word retained unchanged.
- Latency: start bit sampled at edge T0 -> out_valid high after edge T0+1+DATA_W+PARITY_EN+STOP_BITS (T0+11 for defaults).
- Handshake:
  - out_valid stays high and out_data is held until accepted.
  - out_valid falls the cycle after accept unless a new word loads the same edge; in that case out_valid stays high with the new data.
- Error pulses are exactly one cycle, mutually exclusive per frame, and independent of out_ready.
- The receive shift register is separate from the holding register, so receiving continues while a word waits.

Decomposition:
- Shared package serdes_pkg holds:
  - FSM state encoding constants.
  - Frame-format constants: START_BIT=0, IDLE_LEVEL=1, STOP_LEVEL=1.
  - The default DATA_W, also used by the serializer.
- Natural sub-module: rx_hold_reg, the one-entry valid/ready holding register with overrun detection. The FSM and shifter stay in the top module.

Test Plan:
- Reset then 0xA5 (PARITY_EN=1): line 0,1,0,1,0,0,1,0,1, parity 0, stop 1 -> out_valid at T0+11, out_data=0xA5, no error pulses.
- 0x3C sent with parity bit 1 -> parity_err one-cycle pulse at T0+11; out_valid stays 0.
- 0x81 with stop bit 0, line held low 20 cycles, then high, then 0x55 -> one frame_err pulse only; next out_data=0x55.
- 0x11 then 0x22 back-to-back with out_ready=0 -> out_data=0x11 held, overrun pulse on the second frame; after out_ready=1, a single accept of 0x11.
- Frames 0x00, 0xFF, 0x5A zero-gap with out_ready=1 -> three out_valid beats at 11-cycle spacing with correct data.
- nreset low at data bit 4 of 0xC3, released, then 0x0F sent -> no pulses after reset; out_data=0x0F only.
